// File: rtl/frontend_ibuf_pkg.sv
// Shared types and helpers for the frontend response instruction buffer.
// Optional feature macro used by the top: FRONTEND_IBUF_STALL_CNT_EN.
package frontend_ibuf_pkg;

    localparam int unsigned PARCEL_W = 16;
    // Stored pc field width; instances must use PC_W <= PC_W_MAX.
    localparam int unsigned PC_W_MAX = 32;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [PARCEL_W-1:0] bits;
        logic                pf;
        logic                ae;
    } parcel_t;

    function automatic logic is_rvc(input logic [PARCEL_W-1:0] bits);
        return bits[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/frontend_ibuf_decode.sv
// Combinational inspection of the two oldest parcels: builds the instruction
// presented to decode, its validity and how many parcels it consumes.
module frontend_ibuf_decode
    import frontend_ibuf_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 3
) (
    input  logic             flush,
    input  parcel_t          head,
    input  parcel_t          second,
    input  logic [CNT_W-1:0] count,
    output logic             valid_c,
    output logic [PC_W-1:0]  pc_c,
    output logic [31:0]      bits_c,
    output logic             rvc_c,
    output logic             xcpt_pf_c,
    output logic             xcpt_ae_c,
    output logic             xcpt_cross_c,
    output logic [1:0]       consume_c
);

    logic has1;
    logic has2;

    assign has1 = count >= CNT_W'(1);
    assign has2 = count >= CNT_W'(2);

    always_comb begin
        valid_c      = 1'b0;
        pc_c         = '0;
        bits_c       = '0;
        rvc_c        = 1'b0;
        xcpt_pf_c    = 1'b0;
        xcpt_ae_c    = 1'b0;
        xcpt_cross_c = 1'b0;
        consume_c    = 2'd0;

        // Data fields stay zero while the queue is empty.
        if (has1) begin
            pc_c = PC_W'(head.pc);
            if (head.pf || head.ae) begin
                valid_c   = 1'b1;
                rvc_c     = is_rvc(head.bits);
                bits_c    = {16'h0000, head.bits};
                xcpt_pf_c = head.pf;
                xcpt_ae_c = head.ae;
                consume_c = 2'd1;
            end else if (is_rvc(head.bits)) begin
                valid_c   = 1'b1;
                rvc_c     = 1'b1;
                bits_c    = {16'h0000, head.bits};
                consume_c = 2'd1;
            end else if (has2) begin
                valid_c   = 1'b1;
                bits_c    = {second.bits, head.bits};
                consume_c = 2'd2;
                if (second.pf || second.ae) begin
                    xcpt_pf_c    = second.pf;
                    xcpt_ae_c    = second.ae;
                    xcpt_cross_c = 1'b1;
                end
            end
        end

        if (flush) begin
            valid_c   = 1'b0;
            consume_c = 2'd0;
        end
    end

endmodule

// File: rtl/frontend_resp_ibuf.sv
// Frontend response instruction buffer: queues 16-bit parcels from fetch beats
// and hands one instruction per cycle to decode.
// Optional: FRONTEND_IBUF_STALL_CNT_EN adds a saturating decode-starvation counter.
module frontend_resp_ibuf
    import frontend_ibuf_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            resp_valid,
    output logic            resp_ready,
    input  logic [PC_W-1:0] resp_pc,
    input  logic [31:0]     resp_data,
    input  logic [1:0]      resp_mask,
    input  logic            resp_xcpt_pf,
    input  logic            resp_xcpt_ae,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [PC_W-1:0] inst_pc,
    output logic [31:0]     inst_bits,
    output logic            inst_rvc,
    output logic            inst_xcpt_pf,
    output logic            inst_xcpt_ae,
    output logic            inst_xcpt_cross
`ifdef FRONTEND_IBUF_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    parcel_t          mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [1:0]       mask_eff;
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    logic [1:0]       consume;
    logic             enq;
    logic             deq;
    logic [PC_W-1:0]  base;
    parcel_t          p0;
    parcel_t          p1;
    parcel_t          second;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p, input logic [1:0] n);
        case (n)
            2'd0:    return p;
            2'd1:    return ptr_inc(p);
            default: return ptr_inc(ptr_inc(p));
        endcase
    endfunction

    // Enqueue side: readiness depends only on registered occupancy.
    always_comb begin
        mask_eff   = resp_mask;
        if (resp_mask == 2'b00 && (resp_xcpt_pf || resp_xcpt_ae)) begin
            mask_eff = 2'b01;
        end
        resp_ready = !flush && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
        enq        = resp_valid && resp_ready;
        enq_n      = enq ? ({1'b0, mask_eff[0]} + {1'b0, mask_eff[1]}) : 2'd0;
        deq        = inst_valid && inst_ready;
        deq_n      = deq ? consume : 2'd0;
        base       = resp_pc & ~PC_W'(3);
        p0         = '{pc: PC_W_MAX'(base), bits: resp_data[15:0],
                       pf: resp_xcpt_pf, ae: resp_xcpt_ae};
        p1         = '{pc: PC_W_MAX'(base + PC_W'(2)), bits: resp_data[31:16],
                       pf: resp_xcpt_pf, ae: resp_xcpt_ae};
        second     = mem[ptr_inc(head)];
    end

    // Parcel storage; contents past count are never observed, so no reset.
    always_ff @(posedge clock) begin
        if (enq) begin
            case (mask_eff)
                2'b01: mem[tail] <= p0;
                2'b10: mem[tail] <= p1;
                2'b11: begin
                    mem[tail]          <= p0;
                    mem[ptr_inc(tail)] <= p1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= ptr_adv(head, deq_n);
            tail  <= ptr_adv(tail, enq_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    frontend_ibuf_decode #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) u_decode (
        .flush        (flush),
        .head         (mem[head]),
        .second       (second),
        .count        (count),
        .valid_c      (inst_valid),
        .pc_c         (inst_pc),
        .bits_c       (inst_bits),
        .rvc_c        (inst_rvc),
        .xcpt_pf_c    (inst_xcpt_pf),
        .xcpt_ae_c    (inst_xcpt_ae),
        .xcpt_cross_c (inst_xcpt_cross),
        .consume_c    (consume)
    );

`ifdef FRONTEND_IBUF_STALL_CNT_EN
    // Cycles where decode could take an instruction but none is available.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (inst_ready && !inst_valid && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frontend_resp_ibuf.sv
// Self-checking bench for frontend_resp_ibuf: directed scenarios plus random
// traffic checked against a parcel-queue reference model.
module tb_frontend_resp_ibuf;

    localparam int DEPTH = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_data;
    logic [1:0]  resp_mask;
    logic        resp_xcpt_pf;
    logic        resp_xcpt_ae;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_bits;
    logic        inst_rvc;
    logic        inst_xcpt_pf;
    logic        inst_xcpt_ae;
    logic        inst_xcpt_cross;
`ifdef FRONTEND_IBUF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] bits;
        logic        pf;
        logic        ae;
    } mparcel_t;

    mparcel_t mq[$];

    logic        exp_ready, exp_valid, exp_rvc, exp_pf, exp_ae, exp_cross;
    logic [31:0] exp_pc, exp_bits;
    int          exp_consume;

    always #5 clock = ~clock;

    frontend_resp_ibuf #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .flush           (flush),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_pc         (resp_pc),
        .resp_data       (resp_data),
        .resp_mask       (resp_mask),
        .resp_xcpt_pf    (resp_xcpt_pf),
        .resp_xcpt_ae    (resp_xcpt_ae),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_bits       (inst_bits),
        .inst_rvc        (inst_rvc),
        .inst_xcpt_pf    (inst_xcpt_pf),
        .inst_xcpt_ae    (inst_xcpt_ae),
        .inst_xcpt_cross (inst_xcpt_cross)
`ifdef FRONTEND_IBUF_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    // Expected outputs from the model queue and the current inputs.
    function automatic void exp_calc();
        exp_ready   = !flush && ((DEPTH - mq.size()) >= 2);
        exp_valid   = 1'b0;
        exp_consume = 0;
        exp_pc      = '0;
        exp_bits    = '0;
        exp_rvc     = 1'b0;
        exp_pf      = 1'b0;
        exp_ae      = 1'b0;
        exp_cross   = 1'b0;
        if (mq.size() > 0) begin
            exp_pc = mq[0].pc;
            if (mq[0].pf || mq[0].ae) begin
                exp_valid = 1'b1; exp_consume = 1;
                exp_rvc   = (mq[0].bits[1:0] != 2'b11);
                exp_bits  = {16'h0, mq[0].bits};
                exp_pf    = mq[0].pf; exp_ae = mq[0].ae;
            end else if (mq[0].bits[1:0] != 2'b11) begin
                exp_valid = 1'b1; exp_consume = 1; exp_rvc = 1'b1;
                exp_bits  = {16'h0, mq[0].bits};
            end else if (mq.size() >= 2) begin
                exp_valid = 1'b1; exp_consume = 2;
                exp_bits  = {mq[1].bits, mq[0].bits};
                if (mq[1].pf || mq[1].ae) begin
                    exp_pf = mq[1].pf; exp_ae = mq[1].ae; exp_cross = 1'b1;
                end
            end
        end
        if (flush) begin
            exp_valid = 1'b0; exp_consume = 0;
        end
    endfunction

    task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] data,
                         input logic [1:0] mask, input logic pf, input logic ae,
                         input logic ir, input logic fl);
        @(negedge clock);
        resp_valid   = v;
        resp_pc      = pc;
        resp_data    = data;
        resp_mask    = mask;
        resp_xcpt_pf = pf;
        resp_xcpt_ae = ae;
        inst_ready   = ir;
        flush        = fl;
        #1;
    endtask

    task automatic apply_idle(input logic ir);
        apply(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ir, 1'b0);
    endtask

    // Advance one clock, moving the model the way the spec says the queue moves.
    task automatic tick();
        logic [1:0]  m;
        logic [31:0] b;
        exp_calc();
        if (flush) begin
            mq.delete();
        end else begin
            if (exp_valid && inst_ready) begin
                repeat (exp_consume) void'(mq.pop_front());
            end
            if (resp_valid && exp_ready) begin
                m = resp_mask;
                if (m == 2'b00 && (resp_xcpt_pf || resp_xcpt_ae)) m = 2'b01;
                b = resp_pc & ~32'd3;
                if (m[0]) mq.push_back('{pc: b,      bits: resp_data[15:0],  pf: resp_xcpt_pf, ae: resp_xcpt_ae});
                if (m[1]) mq.push_back('{pc: b + 2,  bits: resp_data[31:16], pf: resp_xcpt_pf, ae: resp_xcpt_ae});
            end
        end
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        resp_valid = 1'b0; resp_mask = 2'b00; resp_xcpt_pf = 1'b0; resp_xcpt_ae = 1'b0;
        inst_ready = 1'b0; flush = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        resp_valid = 1'b0; resp_pc = '0; resp_data = '0; resp_mask = 2'b00;
        resp_xcpt_pf = 1'b0; resp_xcpt_ae = 1'b0; inst_ready = 1'b0; flush = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", resp_ready); end
        checks++; if ({inst_pc, inst_bits} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h_%h want 0", inst_pc, inst_bits); end
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_rvc_pass();
        apply(1'b1, 32'h1000, 32'h0013_4501, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rvc_latency: got %b want 0", inst_valid); end
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, inst_pc, inst_bits, inst_rvc} !== {1'b1, 32'h1000, 32'h0000_4501, 1'b1})
            begin errors++; $display("FAIL rvc_inst: got v=%b pc=%h bits=%h rvc=%b want v=1 pc=1000 bits=00004501 rvc=1", inst_valid, inst_pc, inst_bits, inst_rvc); end
        tick();
        apply_idle(1'b1);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rvc_wait_second: got %b want 0", inst_valid); end
        checks++; if (inst_pc !== 32'h1002) begin errors++; $display("FAIL rvc_wait_pc: got %h want 1002", inst_pc); end
        tick();
        do_reset();
    endtask

    task automatic test_straddle();
        apply(1'b1, 32'h2000, 32'h0513_0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        apply(1'b1, 32'h2004, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL straddle_wait: got %b want 0", inst_valid); end
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, inst_pc, inst_bits, inst_rvc} !== {1'b1, 32'h2002, 32'h0000_0513, 1'b0})
            begin errors++; $display("FAIL straddle_inst: got v=%b pc=%h bits=%h rvc=%b want v=1 pc=2002 bits=00000513 rvc=0", inst_valid, inst_pc, inst_bits, inst_rvc); end
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, inst_pc, inst_bits, inst_rvc} !== {1'b1, 32'h2006, 32'h0, 1'b1})
            begin errors++; $display("FAIL straddle_next: got v=%b pc=%h bits=%h rvc=%b want v=1 pc=2006 bits=0 rvc=1", inst_valid, inst_pc, inst_bits, inst_rvc); end
        tick();
        do_reset();
    endtask

    task automatic test_cross_fault();
        apply(1'b1, 32'h3000, 32'h0003_0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 32'h3004, 32'h0000_1234, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, inst_pc, inst_bits, inst_rvc, inst_xcpt_pf, inst_xcpt_ae, inst_xcpt_cross} !==
                      {1'b1, 32'h3002, 32'h1234_0003, 1'b0, 1'b1, 1'b0, 1'b1})
            begin errors++; $display("FAIL cross_fault: got v=%b pc=%h bits=%h rvc=%b pf=%b ae=%b cross=%b want 1 3002 12340003 0 1 0 1",
                inst_valid, inst_pc, inst_bits, inst_rvc, inst_xcpt_pf, inst_xcpt_ae, inst_xcpt_cross); end
        tick();
        do_reset();
    endtask

    task automatic test_full();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h4000 + 32'(4 * i), 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b want 1", i, resp_ready); end
            tick();
        end
        apply(1'b1, 32'h400C, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %b want 0", resp_ready); end
        tick();
        apply(1'b1, 32'h400C, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", resp_ready); end
        tick();
        apply(1'b1, 32'h400C, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL full_depth_m1: got %b want 0", resp_ready); end
        tick();
        apply(1'b1, 32'h400C, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        apply(1'b1, 32'h400C, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", resp_ready); end
        tick();
        apply_idle(1'b0);
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL full_single_parcel: got %b want 0", resp_ready); end
        tick();
        do_reset();
    endtask

    task automatic test_flush();
        apply(1'b1, 32'h5000, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 32'h5004, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 32'h5008, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", resp_ready); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", inst_valid); end
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, resp_ready} !== 2'b01) begin errors++; $display("FAIL flush_after: got v=%b r=%b want v=0 r=1", inst_valid, resp_ready); end
        tick();
        apply(1'b1, 32'h6000, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL flush_accept: got %b want 1", resp_ready); end
        tick();
        apply_idle(1'b1);
        checks++; if ({inst_valid, inst_pc, inst_bits} !== {1'b1, 32'h6000, 32'h1})
            begin errors++; $display("FAIL flush_refill: got v=%b pc=%h bits=%h want v=1 pc=6000 bits=1", inst_valid, inst_pc, inst_bits); end
        tick();
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int n = 0; n < 3000; n++) begin
            d[15:0]  = 16'($urandom);
            d[31:16] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) d[17:16] = 2'b11;
            apply($urandom_range(0, 3) != 0, 32'h8000 + 32'($urandom_range(0, 4095)), d,
                  2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            exp_calc();
            checks++; if (resp_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, resp_ready, exp_ready); end
            checks++; if (inst_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, inst_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if ({inst_pc, inst_bits, inst_rvc, inst_xcpt_pf, inst_xcpt_ae, inst_xcpt_cross} !==
                    {exp_pc, exp_bits, exp_rvc, exp_pf, exp_ae, exp_cross}) begin
                    errors++;
                    $display("FAIL rand_inst[%0d]: got pc=%h bits=%h rvc=%b pf=%b ae=%b x=%b want pc=%h bits=%h rvc=%b pf=%b ae=%b x=%b",
                        n, inst_pc, inst_bits, inst_rvc, inst_xcpt_pf, inst_xcpt_ae, inst_xcpt_cross,
                        exp_pc, exp_bits, exp_rvc, exp_pf, exp_ae, exp_cross);
                end
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        apply(1'b1, 32'h7000, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply_idle(1'b0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", inst_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({inst_valid, resp_ready} !== 2'b01) begin errors++; $display("FAIL areset_during: got v=%b r=%b want v=0 r=1", inst_valid, resp_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
        apply_idle(1'b0);
        checks++; if ({inst_valid, resp_ready} !== 2'b01) begin errors++; $display("FAIL areset_after: got v=%b r=%b want v=0 r=1", inst_valid, resp_ready); end
`ifdef FRONTEND_IBUF_STALL_CNT_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply_idle(1'b1);
            checks++; if (stall_cnt !== 32'(k)) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", k, stall_cnt, k); end
            tick();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rvc_pass();
        test_straddle();
        test_cross_fault();
        test_full();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frontend_resp_ibuf.md
Name: frontend_resp_ibuf

Overview:
- Consumer end of the hart-0 frontend response channel. Accepts fetch beats and emits one decoded-width instruction per cycle toward decode.
- Each beat carries pc, 32-bit data, a 2-bit halfword mask and two fault flags.
- Buffers 16-bit parcels in a circular queue. Reassembles 32-bit instructions that straddle beats and passes RVC (16-bit) instructions through.
- Sits between the frontend response interface and the decode stage.

Parameters:
- DEPTH, 6, parcel entries in the queue; must be even and >= 4.
- PC_W, 32, program-counter width.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  redirect/kill; discards all buffered parcels
- resp_valid  in  1  frontend beat valid
- resp_ready  out  1  beat accepted when valid&&ready
- resp_pc  in  PC_W  beat fetch address
- resp_data  in  32  two halfword parcels; [15:0] is parcel 0
- resp_mask  in  2  bit i set = parcel i valid
- resp_xcpt_pf  in  1  instruction page fault on this beat
- resp_xcpt_ae  in  1  instruction access fault on this beat
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts
- inst_pc  out  PC_W  instruction address
- inst_bits  out  32  instruction; RVC zero-extended
- inst_rvc  out  1  16-bit instruction
- inst_xcpt_pf  out  1  page fault attributed to instruction
- inst_xcpt_ae  out  1  access fault attributed to instruction
- inst_xcpt_cross  out  1  fault came from the second (upper) parcel of a 32-bit instruction

Behaviour:
- Entry = {pc, bits[15:0], pf, ae}. Parcel i address = {resp_pc[PC_W-1:2],2'b00} + 2*i.
- Storage: head/tail pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Enqueue:
  - resp_ready = !flush && (DEPTH - count >= 2), computed from registered count only; no dequeue bypass.
  - On accept, the valid parcels are written in order at tail, tail advances by popcount(mask), and both entries copy pf/ae.
  - Mask 00 without fault: beat accepted and dropped.
  - Mask 00 with fault: treated as mask 01.
- Head decode (combinational from queue):
  - Head faulted (pf|ae): emit single parcel. inst_rvc = (bits[1:0]!=11), xcpt flags from head, cross = 0, consume 1.
  - Else if head bits[1:0] != 2'b11: RVC, inst_bits = {16'b0, p0}, consume 1.
  - Else 32-bit: requires count >= 2. inst_bits = {p1,p0}, inst_pc = head pc, consume 2. If p1 faulted, inst_xcpt_* = p1 flags and cross = 1.
- inst_valid:
  - count >= 1 for RVC or faulted head; count >= 2 for 32-bit.
  - Forced 0 during flush.
- Latency: beat accepted in cycle N; earliest inst_valid in N+1.
- Outputs hold stable while inst_valid && !inst_ready.
- Simultaneous enqueue and dequeue in one cycle: count' = count + enq_n - deq_n.
- Flush: synchronous. Next cycle head = tail = count = 0. A same-cycle beat is not accepted (ready = 0). A same-cycle dequeue is ignored.
- Reset (asynchronous, mid-operation included): pointers and count cleared. Outputs: resp_ready = 1 after reset, inst_valid = 0, data outputs 0 (masked when queue is empty).
- Full boundary: count == DEPTH-1 → resp_ready = 0 even if the beat has only one valid parcel.

Optional Feature:
- Macro: FRONTEND_IBUF_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], a saturating counter incremented each cycle inst_ready && !inst_valid && !flush. Reset value 0; holds at 32'hFFFF_FFFF.
- Undefined: no port, no counter logic.

Decomposition:
- Package frontend_ibuf_pkg holds:
  - typedef parcel_t {pc, bits, pf, ae};
  - constant PARCEL_W = 16;
  - function is_rvc(bits) returning bits[1:0]!=2'b11.
- One sub-module, frontend_ibuf_decode: combinational head/second-entry inspection producing inst_* fields, valid and consume count (0/1/2).

Test Plan:
- Reset then beat pc=0x1000, data=0x0013_4501, mask=11 → cycle+1 inst pc=0x1000 bits=0x0000_4501 rvc=1; next inst pc=0x1002 requires 2nd parcel; queue count=1, inst_valid=0.
- Straddle: beat pc=0x2000 mask=10 data[31:16]=0x0513; beat pc=0x2004 mask=11 data=0x0000_0000 → inst pc=0x2002 bits=0x0000_0513 rvc=0; then RVC pc=0x2006.
- Cross fault: 32-bit lower parcel at 0x3002, next beat pc=0x3004 xcpt_pf=1 mask=01 → inst pc=0x3002 xcpt_pf=1 cross=1.
- Full: hold inst_ready=0 and feed three mask=11 beats with DEPTH=6 → 4th beat sees resp_ready=0 until a dequeue.
- Flush with resp_valid=1 and count=3 → beat not accepted; next cycle inst_valid=0, count=0; following beat accepted.
- Assert reset_n low mid-stream while inst_valid=1 → inst_valid=0 immediately; after release resp_ready=1. Under FRONTEND_IBUF_STALL_CNT_EN, stall_cnt = 0 after reset and counts empty-ready cycles.
